// File: rtl/core_issue_sequencer_pkg.sv
// Shared definitions for the core issue sequencer: instruction width and the
// sequencer FSM state encoding (3 bits).
package core_issue_sequencer_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int SEQ_STATE_WIDTH   = 3;

  typedef enum logic [SEQ_STATE_WIDTH-1:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LAUNCH = 3'd1,
    SEQ_ACK    = 3'd2,
    SEQ_RUN    = 3'd3,
    SEQ_HALT   = 3'd4
  } seq_state_e;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/core_issue_sequencer_fifo.sv
// Synchronous instruction FIFO feeding the issue sequencer.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, data_in   write request and data (ignored when full or clearing)
//   pop             read request (ignored when empty or clearing)
//   clear           synchronous flush: pointers and count return to zero
//   head            entry at the read pointer
//   count           entries held (0..DEPTH)
//   full, empty     occupancy flags
module core_issue_sequencer_fifo
  import core_issue_sequencer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = INSTRUCTION_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             head,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_issue_sequencer.sv
// Issues buffered instructions one at a time to the core and tracks completion.
// Ports:
//   clk, reset                  core clock, asynchronous active-low reset
//   enable                      permits new launches
//   flush                       1-cycle: empty the queue, clear error
//   instr_valid/instr_data      push interface, instr_ready = queue not full
//   core_busy                   core busy status
//   core_start                  1-cycle launch pulse (registered)
//   core_instruction            holding register, changes only on a pop
//   queue_count                 entries queued
//   retired_count               completed instructions, wraps
//   idle                        FSM idle and queue empty
//   error                       sticky ack-timeout flag
//
// state  | meaning
// IDLE   | waiting for enable, a queued entry and core not busy
// LAUNCH | core_start high, ack timer loaded
// ACK    | waiting for core_busy; timer runs down to the timeout
// RUN    | core busy; retire when busy drops
// HALT   | core never acknowledged; wait for flush
module core_issue_sequencer
  import core_issue_sequencer_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int INSTR_W     = INSTRUCTION_WIDTH,
  parameter int ACK_TIMEOUT = 4,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          instr_valid,
  input  logic [INSTR_W-1:0]            instr_data,
  output logic                          instr_ready,
  input  logic                          core_busy,
  output logic                          core_start,
  output logic [INSTR_W-1:0]            core_instruction,
  output logic [count_width(DEPTH)-1:0] queue_count,
  output logic [CNT_W-1:0]              retired_count,
  output logic                          idle,
  output logic                          error
);

  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  seq_state_e         state;
  seq_state_e         state_next;
  logic [TMR_W-1:0]   timer;
  logic [INSTR_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               timer_load;
  logic               timer_dec;
  logic               err_set;
  logic               retire;

  assign push        = instr_valid && !fifo_full && !flush;
  assign instr_ready = !fifo_full;
  assign idle        = (state == SEQ_IDLE) && fifo_empty;

  core_issue_sequencer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clear   (flush),
    .data_in (instr_data),
    .head    (fifo_head),
    .count   (queue_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEQ_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    err_set    = 1'b0;
    retire     = 1'b0;
    case (state)
      SEQ_IDLE: begin
        // A busy core here was started by someone else: hold off.
        if (enable && !fifo_empty && !core_busy && !flush) begin
          pop        = 1'b1;
          state_next = SEQ_LAUNCH;
        end
      end
      SEQ_LAUNCH: begin
        timer_load = 1'b1;
        state_next = SEQ_ACK;
      end
      SEQ_ACK: begin
        if (core_busy) begin
          state_next = SEQ_RUN;
        end else if (timer == '0) begin
          err_set    = 1'b1;
          state_next = SEQ_HALT;
        end else begin
          timer_dec = 1'b1;
        end
      end
      SEQ_RUN: begin
        if (!core_busy) begin
          retire     = 1'b1;
          state_next = SEQ_IDLE;
        end
      end
      SEQ_HALT: begin
        if (flush) state_next = SEQ_IDLE;
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Timer is loaded with ACK_TIMEOUT-1 and counts down, so ACK lasts at
  // most ACK_TIMEOUT cycles before the timeout fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_start       <= 1'b0;
      core_instruction <= '0;
      timer            <= '0;
      retired_count    <= '0;
      error            <= 1'b0;
    end else begin
      core_start <= pop;
      if (pop)             core_instruction <= fifo_head;
      if (timer_load)      timer <= TMR_LOAD;
      else if (timer_dec)  timer <= timer - TMR_W'(1);
      if (retire)          retired_count <= retired_count + CNT_W'(1);
      if (err_set)         error <= 1'b1;
      else if (flush)      error <= 1'b0;
    end
  end

endmodule
